sram_fifo_ctrl: RTL and testbench

Controller that turns the 16 x 8-bit single-port SRAM into a FIFO shared by one producer and one consumer. It sits between the producer/consumer handshakes and the SRAM's `w_en`/`addr`/`d`/`q` pins and owns the read/write pointers and the occupancy count. It arbitrates the single address port between pushes and pops with round-robin priority under contention. Pop data is registered.

---
 rtl/sram_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_sram_fifo_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over a single-port SRAM: owns pointers and occupancy, and
// round-robin arbitrates the one address port between pushes and pops.
module sram_fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          out_req,
  output logic          out_ack,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic [AW:0]   level,
  output logic          sram_w_en,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q
);

  // Handshake: a push completes at the edge where in_valid && in_ready; a pop
  // is granted at the edge where out_ack is high and its data appears one
  // cycle later as a single-cycle out_valid pulse.

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          last_wr_q, last_wr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  logic full, empty, wr_elig, rd_elig, wr_gnt, rd_gnt;

  // rst also gates eligibility so grants drop immediately on async reset.
  always_comb begin
    full    = (count_q == DEPTH);
    empty   = (count_q == '0);
    wr_elig = in_valid && !full && !flush && !rst;
    rd_elig = out_req && !empty && !flush && !rst;
    wr_gnt  = wr_elig && (!rd_elig || !last_wr_q);
    rd_gnt  = rd_elig && (!wr_elig || last_wr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      last_wr_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      last_wr_q   <= last_wr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    last_wr_d   = last_wr_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (flush) begin
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      last_wr_d = 1'b0;
    end else begin
      if (wr_gnt) begin
        wptr_d  = wptr_q + AW'(1);
        count_d = count_q + (AW+1)'(1);
      end
      if (rd_gnt) begin
        rptr_d      = rptr_q + AW'(1);
        count_d     = count_q - (AW+1)'(1);
        out_data_d  = sram_q;
        out_valid_d = 1'b1;
      end
      // Only contended cycles move the round-robin pointer.
      if (wr_elig && rd_elig) begin
        last_wr_d = wr_gnt;
      end
    end
  end

  always_comb begin
    in_ready  = wr_gnt;
    out_ack   = rd_gnt;
    sram_w_en = wr_gnt;
    sram_addr = wr_gnt ? wptr_q : rptr_q;
    sram_d    = in_data;
    out_data  = out_data_q;
    out_valid = out_valid_q;
    level     = count_q;
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: behavioural SRAM plus a queue-based FIFO model
// with alternating priority under contention.
module tb_sram_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_req;
  logic       out_ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic [4:0] level;
  logic       sram_w_en;
  logic [3:0] sram_addr;
  logic [7:0] sram_d;
  logic [7:0] sram_q;

  sram_fifo_ctrl #(.DW(8), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_req   (out_req),
    .out_ack   (out_ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .level     (level),
    .sram_w_en (sram_w_en),
    .sram_addr (sram_addr),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  // Clock / SRAM
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [16];
  assign sram_q = mem[sram_addr];
  always @(posedge clk) begin
    if (sram_w_en) mem[sram_addr] <= sram_d;
  end

  // Scoreboard / reference model
  logic [7:0] exp_q[$];
  bit         write_turn;
  logic       exp_valid;
  logic [7:0] exp_data;
  logic       last_wg;
  logic       last_rg;
  int         n_checks;
  int         n_errs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    write_turn = 1'b1;
    exp_valid  = 1'b0;
    exp_data   = 8'h00;
  endtask

  // One clock cycle: inputs applied after negedge, grants checked before the
  // edge, registered outputs checked just after it.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic orq, input logic fl);
    bit wr_ok, rd_ok, wg, rg;
    in_valid = iv;
    in_data  = d;
    out_req  = orq;
    flush    = fl;
    #1;
    wr_ok = iv && (exp_q.size() < 16) && !fl;
    rd_ok = orq && (exp_q.size() > 0) && !fl;
    if (wr_ok && rd_ok) begin
      wg = write_turn;
      rg = !write_turn;
    end else begin
      wg = wr_ok;
      rg = rd_ok;
    end
    last_wg = wg;
    last_rg = rg;
    check("in_ready", in_ready, wg);
    check("out_ack", out_ack, rg);
    check("sram_w_en", sram_w_en, wg);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      write_turn = 1'b1;
      exp_valid  = 1'b0;
    end else begin
      if (wr_ok && rd_ok) write_turn = !wg;
      if (wg) exp_q.push_back(d);
      if (rg) begin
        exp_data  = exp_q.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
    end
    #1;
    check("level", level, exp_q.size());
    check("out_valid", out_valid, exp_valid);
    check("out_data", out_data, exp_data);
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Stimulus
  initial begin
    logic [7:0] v;
    n_checks = 0;
    n_errs   = 0;
    last_wg  = 1'b0;
    last_rg  = 1'b0;
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    out_req  = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_ack", out_ack, 0);
    check("rst_sram_w_en", sram_w_en, 0);
    check("rst_sram_addr", sram_addr, 0);
    rst = 1'b0;

    // Fill, overflow attempt, drain in order
    for (int i = 0; i < 16; i++) push(8'h11 + 8'(i));
    check("full_level", level, 16);
    push(8'hEE);
    check("full_in_ready_blocked", last_wg, 0);
    for (int i = 0; i < 16; i++) begin
      pop();
      check("drain_out_data", out_data, 8'h11 + 8'(i));
    end
    pop();
    check("empty_out_ack", last_rg, 0);

    // Pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) push(8'($urandom_range(0, 255)));
      for (int i = 0; i < 10; i++) pop();
      check("wrap_level", level, 0);
    end

    // Contention: W,R,W,R,W,R
    for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      check("contend_wr", last_wg, (i % 2) == 0);
      check("contend_rd", last_rg, (i % 2) == 1);
    end
    check("contend_level", level, 4);

    // Full with both requesting, then empty with both requesting
    for (int i = 0; i < 12; i++) push(8'($urandom_range(0, 255)));
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    check("full_both_rd", last_rg, 1);
    check("full_both_wr", last_wg, 0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    while (exp_q.size() > 0) pop();
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    check("empty_both_wr", last_wg, 1);
    check("empty_both_rd", last_rg, 0);
    pop();

    // Flush with level 7 and both requesting
    for (int i = 0; i < 7; i++) push(8'($urandom_range(0, 255)));
    check("preflush_level", level, 7);
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    check("flush_no_wr", last_wg, 0);
    check("flush_no_rd", last_rg, 0);
    check("flush_level", level, 0);
    check("flush_out_valid", out_valid, 0);
    push(8'h5C);
    pop();
    check("postflush_data", out_data, 8'h5C);

    // Async reset between edges
    push(8'h12);
    push(8'h34);
    in_valid = 1'b1;
    in_data  = 8'h56;
    out_req  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_level", level, 0);
    check("async_out_valid", out_valid, 0);
    check("async_in_ready", in_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    push(8'hA5);
    pop();
    check("postrst_data", out_data, 8'hA5);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      v = 8'($urandom_range(0, 255));
      cycle(1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)),
            $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
